mem_stage: RTL

- Pipeline stage directly downstream of the execute stage.
- Captures the execute stage's results (ALU result, store data, instruction, IP, memory controls, writeback-line controls) and runs the data-bus load/store handshake. Stalls the pipeline while an access is outstanding.
- Selects the writeback source and drives the register-file write port.
- The same write port is the forwarding source fed back to execute (write_in, rd_addr, forward).

---
 rtl/srm_pkg.sv | 19 +
 rtl/mem_timeout_ctr.sv | 28 ++
 rtl/mem_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/srm_pkg.sv
// Shared types and field positions for the memory stage.
package srm_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_ILL  = 2'b11
  } wb_src_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  localparam int RD_HI = 25;
  localparam int RD_LO = 21;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles of an outstanding bus request; hit flags that TIMEOUT cycles elapsed.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !hit) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == CW'(TIMEOUT));

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: captures execute results, runs the data-bus access,
// and drives the register-file write port (also the forwarding source).
module mem_stage
  import srm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int IPW     = 30,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic [XLEN-1:0] alu_in,
  input  logic [XLEN-1:0] store_in,
  input  logic [XLEN-1:0] inst_in,
  input  logic [IPW-1:0]  ip_in,
  input  logic            mem_req_in,
  input  logic            mem_we_in,
  input  logic [2:0]      wb_lines_in,
  output logic            stall,
  output logic            bus_req,
  output logic            bus_we,
  output logic [IPW-1:0]  bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_ack,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            align_fault,
  output logic            bus_fault,
  output mem_state_e      dbg_state
);

  logic [XLEN-1:0] s_alu, s_store, s_inst;
  logic [IPW-1:0]  s_ip;
  logic            s_mem_req, s_mem_we, s_valid;
  logic [2:0]      s_wb_lines;

  mem_state_e state, state_next;

  logic            misaligned, access, ctr_hit, timeout_hit, retire, wr_ok;
  logic [4:0]      rd;
  wb_src_e         wb_src;
  logic [IPW+1:0]  link_word;
  logic [XLEN-1:0] wb_next;

  // Bus handshake: bus_req stays high with stable bus_we/bus_addr/bus_wdata
  // until a cycle in which bus_ack is high; that cycle completes the access
  // (load data sampled with it). bus_ack with bus_req low is ignored.
  assign misaligned  = s_mem_req && (s_alu[1:0] != 2'b00);
  assign access      = s_valid && s_mem_req && !misaligned;
  assign timeout_hit = access && ctr_hit;
  assign bus_req     = access && !timeout_hit;
  assign bus_we      = bus_req && s_mem_we;
  assign bus_addr    = s_alu[IPW+1:2];
  assign bus_wdata   = s_store;
  assign stall       = bus_req && !bus_ack;
  assign retire      = s_valid && !stall;
  assign dbg_state   = state;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!stall),
    .en    (stall),
    .hit   (ctr_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (stall)  state_next = ACCESS;
      ACCESS:  if (!stall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Writeback source select; LINK is the byte address of the next instruction.
  assign rd        = s_inst[RD_HI:RD_LO];
  assign wb_src    = wb_src_e'(s_wb_lines[2:1]);
  assign link_word = {s_ip + IPW'(1), 2'b00};

  always_comb begin
    wb_next = s_alu;
    case (wb_src)
      WB_ALU:  wb_next = s_alu;
      WB_MEM:  wb_next = bus_rdata;
      WB_LINK: wb_next = XLEN'(link_word);
      default: wb_next = s_alu;
    endcase
  end

  assign wr_ok = s_wb_lines[0] && (wb_src != WB_ILL) && (rd != 5'd0) &&
                 !misaligned && !timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_alu       <= '0;
      s_store     <= '0;
      s_inst      <= '0;
      s_ip        <= '0;
      s_mem_req   <= 1'b0;
      s_mem_we    <= 1'b0;
      s_wb_lines  <= '0;
      s_valid     <= 1'b0;
      wb_we       <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      align_fault <= 1'b0;
      bus_fault   <= 1'b0;
    end else begin
      if (clk_en && !stall) begin
        s_alu      <= alu_in;
        s_store    <= store_in;
        s_inst     <= inst_in;
        s_ip       <= ip_in;
        s_mem_req  <= mem_req_in;
        s_mem_we   <= mem_we_in;
        s_wb_lines <= wb_lines_in;
        s_valid    <= 1'b1;
      end else if (retire) begin
        s_valid <= 1'b0;
      end
      wb_we       <= retire && wr_ok;
      align_fault <= retire && misaligned;
      bus_fault   <= retire && timeout_hit;
      if (retire) begin
        wb_addr <= rd;
        wb_data <= wb_next;
      end
    end
  end

endmodule
